// File: rtl/serial_router_pkg.sv
// Shared types and constants for the multi-port serial router.
// The PARITY state encoding is always present; it is only reachable
// when the top is built with PARITY_CHECK_EN defined.
package serial_router_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR_PORT = 3'd1,
        HDR_LEN  = 3'd2,
        DATA     = 3'd3,
        DONE     = 3'd4,
        PARITY   = 3'd5
    } state_t;

    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_PORT_W    = 2;
    localparam int DEF_LEN_W     = 5;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int sr_clog2(input int n);
        int w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/router_down_counter.sv
// Loadable down counter holding the payload bits still to route.
// tc flags the last bit (count == 1) so the controller can leave DATA
// on the same strobe that drives the count to zero; it never wraps.
module router_down_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == W'(1));

endmodule

// File: rtl/multi_port_serial_router.sv
// Frame-based serial demultiplexer: start bit, port header, length
// header, payload. Payload bits are routed combinationally to the port
// latched from the header. Optional macro PARITY_CHECK_EN adds a trailing
// even-parity bit (over header and payload) and the parity_ok output.
module multi_port_serial_router
    import serial_router_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int PORT_W    = DEF_PORT_W,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 ser_in,
    output logic [NUM_PORTS-1:0] port_out,
    output logic [NUM_PORTS-1:0] port_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 frame_err,
    output logic [LEN_W-1:0]     remaining,
    output logic [PORT_W-1:0]    cur_port,
`ifdef PARITY_CHECK_EN
    output logic                 parity_ok,
`endif
    output state_t               state_dbg
);

    localparam int BCNT_W = sr_clog2((PORT_W > LEN_W) ? PORT_W : LEN_W);

`ifdef PARITY_CHECK_EN
    localparam state_t END_STATE = PARITY;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t              state, state_nxt;
    logic [BCNT_W-1:0]   bit_cnt;
    logic [PORT_W-1:0]   port_sh;
    logic [LEN_W-1:0]    len_sh;
    logic [PORT_W-1:0]   port_shifted;
    logic [LEN_W-1:0]    len_shifted;
    logic                bit_last;
    logic                port_bad;
    logic                cnt_load;
    logic                cnt_en;
    logic                cnt_tc;
`ifdef PARITY_CHECK_EN
    logic                par_acc;
`endif

    // Header shift values with the current bit appended (MSB-first).
    assign port_shifted = PORT_W'({port_sh, ser_in});
    assign len_shifted  = LEN_W'({len_sh, ser_in});
    assign bit_last     = (bit_cnt == '0);
    assign port_bad     = (int'(port_shifted) >= NUM_PORTS);

    assign cnt_load = (state == HDR_LEN) && clk_en && bit_last;
    assign cnt_en   = (state == DATA) && clk_en;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; DONE is left unconditionally after one clk.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (clk_en && !ser_in) state_nxt = HDR_PORT;
            HDR_PORT: if (clk_en && bit_last) state_nxt = HDR_LEN;
            HDR_LEN:  if (clk_en && bit_last)
                          state_nxt = (len_shifted == '0) ? END_STATE : DATA;
            DATA:     if (clk_en && cnt_tc) state_nxt = END_STATE;
`ifdef PARITY_CHECK_EN
            PARITY:   if (clk_en) state_nxt = DONE;
`endif
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Header shift registers, bit counter, error/parity flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            port_sh   <= '0;
            len_sh    <= '0;
            frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_acc   <= 1'b0;
            parity_ok <= 1'b0;
`endif
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (!ser_in) begin
                        port_sh   <= '0;
                        len_sh    <= '0;
                        frame_err <= 1'b0;
                        bit_cnt   <= BCNT_W'(PORT_W - 1);
`ifdef PARITY_CHECK_EN
                        par_acc   <= 1'b0;
                        parity_ok <= 1'b0;
`endif
                    end
                end
                HDR_PORT: begin
                    port_sh <= port_shifted;
`ifdef PARITY_CHECK_EN
                    par_acc <= par_acc ^ ser_in;
`endif
                    if (bit_last) begin
                        bit_cnt <= BCNT_W'(LEN_W - 1);
                        if (port_bad) frame_err <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - BCNT_W'(1);
                    end
                end
                HDR_LEN: begin
                    len_sh <= len_shifted;
`ifdef PARITY_CHECK_EN
                    par_acc <= par_acc ^ ser_in;
`endif
                    if (!bit_last) bit_cnt <= bit_cnt - BCNT_W'(1);
                end
`ifdef PARITY_CHECK_EN
                DATA: begin
                    par_acc <= par_acc ^ ser_in;
                end
                PARITY: begin
                    parity_ok <= (par_acc == ser_in);
                    if (par_acc != ser_in) frame_err <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    router_down_counter #(.W(LEN_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (len_shifted),
        .en       (cnt_en),
        .count    (remaining),
        .tc       (cnt_tc)
    );

    // Zero-latency routing of ser_in to the selected, in-range port.
    always_comb begin
        port_out   = '0;
        port_valid = '0;
        if ((state == DATA) && !frame_err) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (port_sh == PORT_W'(i)) begin
                    port_valid[i] = 1'b1;
                    port_out[i]   = ser_in;
                end
            end
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign cur_port  = port_sh;
    assign state_dbg = state;

endmodule

// File: tb/tb_multi_port_serial_router.sv
// Directed bench for multi_port_serial_router: a default 4-port instance
// and a 3-port instance share the same serial stream. Build with
// PARITY_CHECK_EN defined to exercise the trailing parity bit.
module tb_multi_port_serial_router;
    import serial_router_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_en = 1'b0;
    logic ser_in = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT outputs ----------------
    logic [3:0] port_out, port_valid;
    logic       busy, done, frame_err;
    logic [4:0] remaining;
    logic [1:0] cur_port;
    state_t     state_dbg;

    logic [2:0] port_out3, port_valid3;
    logic       busy3, done3, frame_err3;
    logic [4:0] remaining3;
    logic [1:0] cur_port3;
    state_t     state_dbg3;
`ifdef PARITY_CHECK_EN
    logic       parity_ok, parity_ok3;
`endif

    multi_port_serial_router u_dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .ser_in(ser_in),
        .port_out(port_out), .port_valid(port_valid), .busy(busy),
        .done(done), .frame_err(frame_err), .remaining(remaining),
        .cur_port(cur_port),
`ifdef PARITY_CHECK_EN
        .parity_ok(parity_ok),
`endif
        .state_dbg(state_dbg)
    );

    multi_port_serial_router #(.NUM_PORTS(3)) u_dut3 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .ser_in(ser_in),
        .port_out(port_out3), .port_valid(port_valid3), .busy(busy3),
        .done(done3), .frame_err(frame_err3), .remaining(remaining3),
        .cur_port(cur_port3),
`ifdef PARITY_CHECK_EN
        .parity_ok(parity_ok3),
`endif
        .state_dbg(state_dbg3)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Event counters sampled away from the active edge.
    int done_cnt = 0, done3_cnt = 0, valid_cnt = 0;
    always @(negedge clk) begin
        if (done)        done_cnt++;
        if (done3)       done3_cnt++;
        if (|port_valid) valid_cnt++;
    end

    // ---------------- driver tasks ----------------
    logic par;

    task automatic strobe(input logic b);
        @(negedge clk);
        clk_en = 1'b1;
        ser_in = b;
        #1;
    endtask

    task automatic hold();
        @(negedge clk);
        clk_en = 1'b0;
        #1;
    endtask

    task automatic idle_gap();
        @(negedge clk);
        clk_en = 1'b1;
        ser_in = 1'b1;
        #1;
    endtask

    task automatic send_header(input logic [1:0] p, input logic [4:0] l);
        par = 1'b0;
        strobe(1'b0);
        for (int i = 1; i >= 0; i--) begin strobe(p[i]); par ^= p[i]; end
        for (int i = 4; i >= 0; i--) begin strobe(l[i]); par ^= l[i]; end
    endtask

    task automatic data_bit(input logic b);
        strobe(b);
        par ^= b;
    endtask

    // Leaves the bench inside the DONE window.
    task automatic end_frame(input logic flip);
`ifdef PARITY_CHECK_EN
        strobe(par ^ flip);
`else
        par = par ^ flip;
`endif
        hold();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- stimulus ----------------
    int d0, d30, v0;
    logic [2:0] pay3;
    logic [3:0] pay4;
    int gaps[3];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_port_out",   port_out,   0);
        check("rst_port_valid", port_valid, 0);
        check("rst_busy",       busy,       0);
        check("rst_done",       done,       0);
        check("rst_frame_err",  frame_err,  0);
        check("rst_remaining",  remaining,  0);
        check("rst_cur_port",   cur_port,   0);
        check("rst_state",      state_dbg,  IDLE);
        @(negedge clk);
        rst = 1'b1;
        idle_gap();
        idle_gap();

        // T1: port 2, len 3, payload 1,0,1
        d0 = done_cnt;
        send_header(2'b10, 5'd3);
        pay3 = 3'b101;
        for (int i = 0; i < 3; i++) begin
            data_bit(pay3[2-i]);
            check("t1_port_out",   port_out,   pay3[2-i] ? 4'b0100 : 4'b0000);
            check("t1_port_valid", port_valid, 4'b0100);
            check("t1_remaining",  remaining,  3 - i);
            check("t1_cur_port",   cur_port,   2);
        end
        check("t1_dut3_port_out", port_out3, 3'b100);
        end_frame(1'b0);
        check("t1_done",      done,      1);
        check("t1_rem_zero",  remaining, 0);
        check("t1_frame_err", frame_err, 0);
`ifdef PARITY_CHECK_EN
        check("t1_parity_ok", parity_ok, 1);
`endif
        idle_gap();
        check("t1_done_low",  done, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_done_once", done_cnt - d0, 1);

        // T2: zero-length frame to port 1
        d0 = done_cnt;
        v0 = valid_cnt;
        send_header(2'b01, 5'd0);
        end_frame(1'b0);
        check("t2_done",       done,       1);
        check("t2_port_valid", port_valid, 0);
        idle_gap();
        check("t2_no_valid",  valid_cnt - v0, 0);
        check("t2_done_once", done_cnt - d0, 1);

        // T3: port 3 is out of range for the 3-port instance
        d30 = done3_cnt;
        send_header(2'b11, 5'd2);
        for (int i = 0; i < 2; i++) begin
            data_bit(1'b1);
            check("t3_port_out3",   port_out3,   0);
            check("t3_port_valid3", port_valid3, 0);
            check("t3_frame_err3",  frame_err3,  1);
            check("t3_remaining3",  remaining3,  2 - i);
            check("t3_port_out4",   port_out,    4'b1000);
        end
        end_frame(1'b0);
        check("t3_done3", done3, 1);
        idle_gap();
        check("t3_done3_once",  done3_cnt - d30, 1);
        check("t3_err_sticky",  frame_err3, 1);

        // T4: port 0, len 4, irregular clk_en gaps during DATA
        send_header(2'b00, 5'd4);
        check("t4_err_cleared", frame_err3, 0);
        pay4 = 4'b1001;
        gaps[0] = 2; gaps[1] = 0; gaps[2] = 3;
        for (int i = 0; i < 4; i++) exp_q.push_back(pay4[3-i]);
        for (int i = 0; i < 4; i++) begin
            data_bit(pay4[3-i]);
            check("t4_bit",       port_out[0], exp_q.pop_front());
            check("t4_valid",     port_valid,  4'b0001);
            check("t4_remaining", remaining,   4 - i);
            if (i < 3) begin
                for (int g = 0; g < gaps[i]; g++) begin
                    hold();
                    check("t4_gap_remaining", remaining,  3 - i);
                    check("t4_gap_port_out",  port_out,   pay4[3-i] ? 4'b0001 : 4'b0000);
                    check("t4_gap_valid",     port_valid, 4'b0001);
                end
            end
        end
        end_frame(1'b0);
        check("t4_done", done, 1);
        idle_gap();

        // T5: reset mid-DATA with remaining = 4
        d0 = done_cnt;
        send_header(2'b01, 5'd6);
        data_bit(1'b1);
        data_bit(1'b0);
        data_bit(1'b1);
        check("t5_rem_before", remaining, 4);
        #1 rst = 1'b0;
        #1;
        check("t5_port_out",   port_out,   0);
        check("t5_port_valid", port_valid, 0);
        check("t5_busy",       busy,       0);
        check("t5_remaining",  remaining,  0);
        check("t5_state",      state_dbg,  IDLE);
        hold();
        @(negedge clk);
        rst = 1'b1;
        clk_en = 1'b1;
        ser_in = 1'b1;
        check("t5_no_done", done_cnt - d0, 0);
        idle_gap();
        send_header(2'b11, 5'd1);
        data_bit(1'b1);
        check("t5_after_port_out",   port_out,   4'b1000);
        check("t5_after_port_valid", port_valid, 4'b1000);
        end_frame(1'b0);
        check("t5_after_done", done, 1);
        idle_gap();

`ifdef PARITY_CHECK_EN
        // T6: correct parity, then flipped parity
        send_header(2'b10, 5'd2);
        data_bit(1'b1);
        data_bit(1'b0);
        end_frame(1'b0);
        check("t6_parity_ok_good", parity_ok, 1);
        check("t6_frame_err_good", frame_err, 0);
        idle_gap();
        send_header(2'b10, 5'd2);
        data_bit(1'b1);
        data_bit(1'b0);
        end_frame(1'b1);
        check("t6_parity_ok_bad", parity_ok, 0);
        check("t6_frame_err_bad", frame_err, 1);
        check("t6_done_bad",      done,      1);
        idle_gap();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_port_serial_router.md
Name: multi_port_serial_router

Overview:
- Frame-based serial demultiplexer and the successor of the fixed 4-port/5-bit-length transmitter datapath.
- Receives frames on one serial line: start bit, port-index header, length header, then payload. Routes each payload bit to the selected output port.
- Port count and length width are parametrised. Adds the integrated controller FSM, zero-length frames, out-of-range port rejection, a done pulse and status outputs.
- Sits between the one-pulser (clk_en source) and the downstream per-port consumers and display.

Parameters:
- NUM_PORTS, 4, number of output ports (2..16).
- PORT_W, 2, port header width; NUM_PORTS <= 2**PORT_W.
- LEN_W, 5, length header width; maximum payload is 2**LEN_W-1 bits.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- clk_en  input  1  bit strobe; all state advances only on clk edges with clk_en=1.
- ser_in  input  1  serial frame input, idle-high.
- port_out  output  NUM_PORTS  demuxed payload bit; only the selected bit carries ser_in, all others 0.
- port_valid  output  NUM_PORTS  one-hot; selected port high during DATA, else all 0.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-clk pulse on frame completion.
- frame_err  output  1  sticky; set on out-of-range port index, cleared at the next frame start.
- remaining  output  LEN_W  payload bits still to route, for the seven-segment display.
- cur_port  output  PORT_W  latched port index.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; shift registers and counters 0.
- State advances only on clk edges with clk_en=1. The one exception is the done pulse, which is one clk long.
- Header bits are sampled MSB-first. Each bit counter counts PORT_W-1 or LEN_W-1 down to 0.
- IDLE:
  - ser_in=0 -> HDR_PORT.
  - Clears frame_err and the header shift registers.
- HDR_PORT:
  - Shifts PORT_W bits into the port register.
  - After the last bit -> HDR_LEN.
  - Index >= NUM_PORTS sets frame_err.
- HDR_LEN:
  - Shifts LEN_W bits.
  - After the last bit, remaining loads the length.
  - Length 0 -> DONE. Otherwise -> DATA.
- DATA:
  - port_out/port_valid are driven combinationally from ser_in and cur_port. Zero latency: routed bit = ser_in sampled in that clk_en window.
  - remaining decrements on each clk_en. At remaining=1 with clk_en -> DONE.
  - If frame_err=1, bits are consumed but port_out and port_valid stay 0.
- DONE:
  - done=1 for one clk -> IDLE.
  - Does not wait for clk_en.
  - A ser_in=0 in the same cycle is ignored; start is detected from the next clk_en.
- Non-power-of-two NUM_PORTS: indices NUM_PORTS..2**PORT_W-1 take the error path.
- clk_en=0: every register holds, including during DATA.
- Reset mid-frame aborts the frame immediately. No done pulse; outputs go to 0.
- remaining never underflows. It reads 0 in IDLE/DONE.

Optional Feature:
- Macro PARITY_CHECK_EN.
- Defined: one even-parity bit follows the payload (state PARITY, entered from DATA or from a zero-length HDR_LEN).
  - Parity covers header and payload bits.
  - A mismatch sets frame_err before DONE.
  - Output parity_ok (1 bit) is valid with done.
- Undefined: no PARITY state; frame ends after the last payload bit; parity_ok port is absent.

Decomposition:
- Package serial_router_pkg:
  - state enum: IDLE, HDR_PORT, HDR_LEN, DATA, DONE, PARITY.
  - default parameter constants.
  - a clog2-style width function.
- One sub-module: router_down_counter. It is a loadable LEN_W down counter with enable, terminal-count flag and async active-low reset, and drives remaining.

Test Plan:
- Default params; frame start 0, port 2'b10, len 5'd3, payload 1,0,1 -> port_out[2] = 1,0,1 with port_valid=4'b0100; remaining 3,2,1,0; done pulse once; frame_err=0.
- len=0 to port 1 -> no port_valid assertion; done one clk after the last length bit.
- NUM_PORTS=3, port index 3, len 2 -> frame_err=1; port_out and port_valid all 0 through DATA; done still pulses; next frame clears frame_err.
- Toggle clk_en with irregular gaps during DATA -> remaining and outputs hold between strobes; the same bit sequence arrives on the port.
- rst low mid-DATA with remaining=4 -> outputs 0 immediately; state IDLE; no done; next frame routes correctly.
- PARITY_CHECK_EN defined; correct then flipped parity bit -> parity_ok=1 / frame_err=0, then parity_ok=0 / frame_err=1.
